imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 161 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a two-entry valid/ready output buffer (main + skid).
// in_ready is registered, so out_ready never reaches the upstream handshake combinationally.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      Instr_Rd,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmExt,
    output logic [TAG_W-1:0] out_tag,
    output logic             ImmIllegal
);

    localparam int unsigned ShamtW = 6;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } entryT;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} stateT;

    stateT stateQ;
    stateT stateNext;
    entryT mainQ;
    entryT skidQ;
    entryT inEntry;
    logic  inReadyQ;

    logic [31:0]       imm32;
    logic [ShamtW-1:0] shamt;
    logic              signExt;
    logic              illComb;
    logic              accept;
    logic              consume;
    logic              loadMainIn;
    logic              loadMainSkid;
    logic              loadSkid;

    // Opcode bits never contribute to any immediate format.
    logic unusedOpcode;
    assign unusedOpcode = ^Instr_Rd[6:0];

    assign shamt = (XLEN == 64) ? Instr_Rd[25:20] : {1'b0, Instr_Rd[24:20]};

    // Immediate decode into a 32-bit value, then sign- or zero-extend to XLEN.
    always_comb begin
        imm32   = '0;
        signExt = 1'b1;
        illComb = 1'b0;
        case (ImmSrc)
            3'b000: imm32 = {{20{Instr_Rd[31]}}, Instr_Rd[31:20]};
            3'b001: imm32 = {{20{Instr_Rd[31]}}, Instr_Rd[31:25], Instr_Rd[11:7]};
            3'b010: imm32 = {{19{Instr_Rd[31]}}, Instr_Rd[31], Instr_Rd[7],
                             Instr_Rd[30:25], Instr_Rd[11:8], 1'b0};
            3'b011: imm32 = {Instr_Rd[31:12], 12'h000};
            3'b100: imm32 = {{11{Instr_Rd[31]}}, Instr_Rd[31], Instr_Rd[19:12],
                             Instr_Rd[20], Instr_Rd[30:21], 1'b0};
            3'b101: begin
                imm32   = {26'd0, shamt};
                signExt = 1'b0;
            end
            default: begin
                imm32   = '0;
                signExt = 1'b0;
                illComb = 1'b1;
            end
        endcase
    end

    always_comb begin
        inEntry     = '0;
        inEntry.imm = signExt ? XLEN'($signed(imm32)) : XLEN'(imm32);
        inEntry.tag = in_tag;
        inEntry.ill = illComb;
    end

    assign accept  = in_valid && inReadyQ;
    assign consume = (stateQ != EMPTY) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= EMPTY;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Next state; flush overrides every other transition.
    always_comb begin
        stateNext = stateQ;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            case (stateQ)
                EMPTY: if (accept) stateNext = ONE;
                ONE: begin
                    if (accept && !consume) begin
                        stateNext = TWO;
                    end else if (!accept && consume) begin
                        stateNext = EMPTY;
                    end
                end
                TWO: if (consume) stateNext = ONE;
                default: stateNext = EMPTY;
            endcase
        end
    end

    // Buffer load controls.
    always_comb begin
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (!flush) begin
            case (stateQ)
                EMPTY: loadMainIn = accept;
                ONE: begin
                    loadMainIn = accept && consume;
                    loadSkid   = accept && !consume;
                end
                TWO: loadMainSkid = consume;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainQ    <= '0;
            skidQ    <= '0;
            inReadyQ <= 1'b1;
        end else begin
            inReadyQ <= (stateNext != TWO);
            if (loadMainIn) begin
                mainQ <= inEntry;
            end else if (loadMainSkid) begin
                mainQ <= skidQ;
            end
            if (loadSkid) begin
                skidQ <= inEntry;
            end
        end
    end

    assign in_ready   = inReadyQ;
    assign out_valid  = (stateQ != EMPTY);
    assign ImmExt     = mainQ.imm;
    assign out_tag    = mainQ.tag;
    assign ImmIllegal = mainQ.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: decode vector table, handshake corner sequences and a
// random phase, all checked through an in-order scoreboard.
module tb_imm_gen_pipe;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      Instr_Rd;
    logic [2:0]       ImmSrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  ImmExt;
    logic [TAG_W-1:0] out_tag;
    logic             ImmIllegal;

    typedef struct {
        logic [31:0]      instr;
        logic [2:0]       src;
        logic [TAG_W-1:0] tag;
        logic [31:0]      imm;
        logic             ill;
    } vecT;

    typedef struct {
        logic [31:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } expT;

    expT         sb[$];
    vecT         vecs[13];
    logic [31:0] drvImm;
    logic        drvIll;
    int          checks = 0;
    int          errors = 0;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Instr_Rd  (Instr_Rd),
        .ImmSrc    (ImmSrc),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ImmExt    (ImmExt),
        .out_tag   (out_tag),
        .ImmIllegal(ImmIllegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode built from shifts and masks on the raw word.
    function automatic logic [32:0] model(input logic [31:0] ins, input logic [2:0] src);
        logic signed [31:0] s;
        logic [31:0] a20, a19, a11, r;
        s   = $signed(ins);
        a20 = s >>> 20;
        a19 = s >>> 19;
        a11 = s >>> 11;
        case (src)
            3'd0: r = a20;
            3'd1: r = (a20 & ~32'h1F) | ((ins >> 7) & 32'h1F);
            3'd2: r = (a19 & ~32'hFFF) | ((ins << 4) & 32'h800)
                    | ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
            3'd3: r = ins & 32'hFFFFF000;
            3'd4: r = (a11 & ~32'hFFFFF) | (ins & 32'hFF000)
                    | ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
            3'd5: r = (ins >> 20) & 32'h1F;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, r};
    endfunction

    // Scoreboard: push on accept, pop on consume; flush/reset discard everything.
    always @(negedge clk) begin : monitor
        expT e;
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual_tag=0x%0h required=none at %0t", out_tag, $time);
                end else begin
                    e = sb.pop_front();
                    chk("out_imm", ImmExt, e.imm);
                    chk("out_tag", 32'(out_tag), 32'(e.tag));
                    chk("out_ill", 32'(ImmIllegal), 32'(e.ill));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{drvImm, in_tag, drvIll});
            end
        end
    end

    task automatic setIn(input logic [31:0] ins, input logic [2:0] src, input logic [TAG_W-1:0] tag,
                         input logic [31:0] eImm, input logic eIll);
        Instr_Rd = ins;
        ImmSrc   = src;
        in_tag   = tag;
        drvImm   = eImm;
        drvIll   = eIll;
        in_valid = 1'b1;
    endtask

    task automatic setInM(input logic [31:0] ins, input logic [2:0] src, input logic [TAG_W-1:0] tag);
        logic [32:0] m;
        m = model(ins, src);
        setIn(ins, src, tag, m[31:0], m[32]);
    endtask

    // Hold in_valid until an edge takes it; returns at posedge+1.
    task automatic waitAccept();
        logic got;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!got && n < 50);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted at %0t", $time);
        end
        in_valid = 1'b0;
    endtask

    task automatic sendM(input logic [31:0] ins, input logic [2:0] src, input logic [TAG_W-1:0] tag);
        setInM(ins, src, tag);
        waitAccept();
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [32:0] m;
        vecs[0]  = '{32'hFFF00093, 3'd0, 5'd1,  32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h7FF00013, 3'd0, 5'd2,  32'h000007FF, 1'b0};
        vecs[2]  = '{32'hFE212E23, 3'd1, 5'd3,  32'hFFFFFFFC, 1'b0};
        vecs[3]  = '{32'h00A12423, 3'd1, 5'd4,  32'h00000008, 1'b0};
        vecs[4]  = '{32'hFE000CE3, 3'd2, 5'd5,  32'hFFFFFFF8, 1'b0};
        vecs[5]  = '{32'h80000037, 3'd3, 5'd6,  32'h80000000, 1'b0};
        vecs[6]  = '{32'h12345037, 3'd3, 5'd7,  32'h12345000, 1'b0};
        vecs[7]  = '{32'h0000006F, 3'd4, 5'd8,  32'h00000000, 1'b0};
        vecs[8]  = '{32'hFFDFF06F, 3'd4, 5'd9,  32'hFFFFFFFC, 1'b0};
        vecs[9]  = '{32'h41F0D093, 3'd5, 5'd10, 32'h0000001F, 1'b0};
        vecs[10] = '{32'h02500093, 3'd5, 5'd11, 32'h00000005, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, 3'd6, 5'd12, 32'h00000000, 1'b1};
        vecs[12] = '{32'h12345678, 3'd7, 5'd13, 32'h00000000, 1'b1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Instr_Rd  = '0;
        ImmSrc    = '0;
        in_tag    = '0;
        drvImm    = '0;
        drvIll    = 1'b0;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_imm", ImmExt, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_ill", 32'(ImmIllegal), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);

        // Decode table, back-to-back with the sink always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            chk("tbl_in_ready", 32'(in_ready), 32'd1);
            setIn(vecs[i].instr, vecs[i].src, vecs[i].tag, vecs[i].imm, vecs[i].ill);
            waitAccept();
            chk("tbl_latency_valid", 32'(out_valid), 32'd1);
            chk("tbl_imm", ImmExt, vecs[i].imm);
            chk("tbl_tag", 32'(out_tag), 32'(vecs[i].tag));
            chk("tbl_ill", 32'(ImmIllegal), 32'(vecs[i].ill));
        end
        cycles(2);
        chk("tbl_drained", 32'(sb.size()), 32'd0);

        // Backpressure: two accepted, third held off until the sink drains.
        out_ready = 1'b0;
        sendM(32'h00100093, 3'd0, 5'd1);
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        sendM(32'h00200093, 3'd0, 5'd2);
        chk("bp_ready_two", 32'(in_ready), 32'd0);
        setInM(32'h00300093, 3'd0, 5'd3);
        repeat (3) begin
            cycles(1);
            chk("bp_stall_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_tag", 32'(out_tag), 32'd1);
            chk("bp_hold_imm", ImmExt, 32'd1);
        end
        out_ready = 1'b1;
        waitAccept();
        cycles(4);
        chk("bp_empty_valid", 32'(out_valid), 32'd0);
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Flush while TWO with a pending input.
        out_ready = 1'b0;
        sendM(32'hFE212E23, 3'd1, 5'd20);
        sendM(32'hFE000CE3, 3'd2, 5'd21);
        setInM(32'h80000037, 3'd3, 5'd22);
        flush     = 1'b1;
        out_ready = 1'b1;
        cycles(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush2_valid", 32'(out_valid), 32'd0);
        chk("flush2_ready", 32'(in_ready), 32'd1);
        cycles(3);
        chk("flush2_stays_empty", 32'(out_valid), 32'd0);

        // Flush while ONE with simultaneous accept and consume.
        sendM(32'h0000006F, 3'd4, 5'd23);
        setInM(32'hFFF00093, 3'd0, 5'd24);
        flush = 1'b1;
        cycles(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush1_valid", 32'(out_valid), 32'd0);
        chk("flush1_ready", 32'(in_ready), 32'd1);
        cycles(3);
        chk("flush1_stays_empty", 32'(out_valid), 32'd0);

        // Reset pulse between edges while TWO.
        out_ready = 1'b0;
        sendM(32'hFFF00093, 3'd0, 5'd25);
        sendM(32'h41F0D093, 3'd5, 5'd26);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_imm", ImmExt, 32'd0);
        chk("arst_tag", 32'(out_tag), 32'd0);
        chk("arst_ill", 32'(ImmIllegal), 32'd0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sendM(32'hFE000CE3, 3'd2, 5'd27);
        chk("arst_first_valid", 32'(out_valid), 32'd1);
        chk("arst_first_tag", 32'(out_tag), 32'd27);
        cycles(2);
        chk("arst_drained", 32'(sb.size()), 32'd0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            Instr_Rd  = $urandom;
            ImmSrc    = 3'($urandom_range(0, 7));
            in_tag    = TAG_W'($urandom);
            m         = model(Instr_Rd, ImmSrc);
            drvImm    = m[31:0];
            drvIll    = m[32];
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            cycles(1);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles(4);
        chk("rand_drained", 32'(sb.size()), 32'd0);
        chk("rand_empty_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
